// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the combinational instruction memory
// and buffers {pc, instr} pairs in a small prefetch queue drained by decode.
module instr_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned QDEPTH    = 2,
   parameter int unsigned MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        fault,
   output logic [31:0] fault_pc
);

   localparam int unsigned PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW    = PW + 1;
   localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   fpc, fpc_nxt, fault_pc_nxt;
   logic [31:0]   q_pc    [QDEPTH];
   logic [31:0]   q_instr [QDEPTH];
   logic [PW-1:0] rptr, wptr;
   logic [CW-1:0] count;
   logic          pop, push, flush, in_range, redir_misaligned, redir_in_range;

   assign imem_addr        = fpc;
   assign if_valid         = (count != '0);
   assign if_pc            = q_pc[rptr];
   assign if_instr         = q_instr[rptr];
   assign pop              = if_valid & if_ready;
   assign in_range         = (fpc < LIMIT);
   assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
   assign redir_in_range   = (redirect_pc < LIMIT);

   // Next-state: a redirect outranks everything; fault is exited only by a legal target
   always_comb begin
      state_nxt    = state;
      fpc_nxt      = fpc;
      fault_pc_nxt = fault_pc;
      push         = 1'b0;
      flush        = 1'b0;
      if (redirect_valid) begin
         flush = 1'b1;
         if (redir_misaligned) begin
            state_nxt    = FAULT;
            fault_pc_nxt = redirect_pc;
         end else begin
            fpc_nxt = redirect_pc;
            if ((state != FAULT) || redir_in_range) begin
               state_nxt = fetch_en ? RUN : IDLE;
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (fetch_en) begin
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (!in_range) begin
                  state_nxt    = FAULT;
                  fault_pc_nxt = fpc;
               end else begin
                  if ((count < CW'(QDEPTH)) || pop) begin
                     push    = 1'b1;
                     fpc_nxt = fpc + 32'd4;
                  end
                  if (!fetch_en) begin
                     state_nxt = IDLE;
                  end
               end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fpc      <= RESET_PC;
         fault    <= 1'b0;
         fault_pc <= 32'h0;
      end else begin
         state    <= state_nxt;
         fpc      <= fpc_nxt;
         fault    <= (state_nxt == FAULT);
         fault_pc <= fault_pc_nxt;
      end
   end

   // Prefetch queue; a flush discards everything, including the entry popped this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         for (int i = 0; i < int'(QDEPTH); i++) begin
            q_pc[i]    <= 32'h0;
            q_instr[i] <= 32'h0;
         end
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            q_pc[wptr]    <= fpc;
            q_instr[wptr] <= imem_rd;
            wptr          <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule
